// File: rtl/fp32_add_sched_pkg.sv
// fp32_add_sched_pkg: state encodings, register sizes and the timeout result
package fp32_add_sched_pkg;
   localparam int OP_BITS = 64;
   localparam int RES_BITS = 32;
   localparam logic [RES_BITS-1:0] TMO_RESULT = '0;
   typedef enum logic [2:0] {ST_IDLE, ST_GO, ST_LOAD, ST_WAIT, ST_UNLOAD, ST_RESP} state_t;
endpackage

// File: rtl/fp32_add_sched_if.sv
// fp32_add_sched_if: two operand request ports and the result response port
interface fp32_add_sched_if;
   import fp32_add_sched_pkg::*;
   logic req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic rsp_valid, rsp_ready, rsp_id, rsp_over, rsp_under, rsp_timeout;
   logic [RES_BITS-1:0] rsp_data;
   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_over, rsp_under, rsp_timeout
   );
   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_over, rsp_under, rsp_timeout
   );
endinterface

// File: rtl/fp32_add_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on a tie the port not granted last wins
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       gnt_id
);
   logic last_id;
   // port 1 wins when it asks alone or when port 0 had the previous grant
   always_comb begin
      gnt_id = req[1] & (~req[0] | ~last_id);
      gnt = {2{en}} & req & (gnt_id ? 2'b10 : 2'b01);
   end
   // remember the latest winner; starting at 1 hands port 0 the first tie
   always_ff @(posedge clk or negedge reset)
      if (!reset) last_id <= 1'b1;
      else if (|gnt) last_id <= gnt_id;
endmodule

// File: rtl/fp32_add_sched.sv
// fp32_add_sched: arbitrates two requesters and serialises jobs through the serial fp32 adder
module fp32_add_sched import fp32_add_sched_pkg::*; #(
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   fp32_add_sched_if.slave  bus,
   output logic             busy,
   output logic             fa_go,
   output logic             fa_inpab,
   input  logic             fa_shift,
   input  logic             fa_out_c,
   input  logic             fa_over,
   input  logic             fa_under,
   input  logic             fa_done
);
   state_t state, state_nx;
   logic [OP_BITS-1:0] op;
   logic [RES_BITS-1:0] res;
   logic [5:0] cnt;
   logic [15:0] tmr;
   logic [1:0] gnt;
   logic gnt_id, tmo, abort, over, under, tout, id;
   rr_arb2 u_arb (
      .clk(clk),
      .reset(reset),
      .req({bus.req1_valid, bus.req0_valid}),
      .en(state == ST_IDLE && reset),
      .gnt(gnt),
      .gnt_id(gnt_id)
   );
   // a stalled adder or a done that drops early ends the job with a timeout response
   always_comb begin
      tmo = tmr == 16'(TIMEOUT - 1);
      abort = (((state == ST_LOAD) && !fa_shift) || ((state == ST_WAIT) && !fa_done)) && tmo
              || ((state == ST_UNLOAD) && !fa_done);
   end
   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= ST_IDLE;
      else state <= state_nx;
   // next-state selection
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   state_nx = |gnt ? ST_GO : ST_IDLE;
         ST_GO:     state_nx = ST_LOAD;
         ST_LOAD:   state_nx = abort ? ST_RESP : (fa_shift && cnt == 6'd63) ? ST_WAIT : ST_LOAD;
         ST_WAIT:   state_nx = abort ? ST_RESP : fa_done ? ST_UNLOAD : ST_WAIT;
         ST_UNLOAD: state_nx = (abort || cnt == 6'd31) ? ST_RESP : ST_UNLOAD;
         ST_RESP:   state_nx = bus.rsp_ready ? ST_IDLE : ST_RESP;
         default:   state_nx = ST_IDLE;
      endcase
   end
   // outputs: strobes decode the state, response fields come straight from registers
   always_comb begin
      busy = state != ST_IDLE;
      fa_go = state == ST_GO;
      fa_inpab = op[OP_BITS-1];
      bus.req0_ready = gnt[0];
      bus.req1_ready = gnt[1];
      bus.rsp_valid = state == ST_RESP;
      bus.rsp_id = id;
      bus.rsp_data = res;
      bus.rsp_over = over;
      bus.rsp_under = under;
      bus.rsp_timeout = tout;
   end
   // operand/result shift registers, bit counter and stall timer
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         op <= '0;
         res <= '0;
         cnt <= '0;
         tmr <= '0;
         over <= 1'b0;
         under <= 1'b0;
         tout <= 1'b0;
         id <= 1'b0;
      end else if (abort) begin
         res <= TMO_RESULT;
         over <= 1'b0;
         under <= 1'b0;
         tout <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: if (|gnt) begin
               op <= gnt_id ? {bus.req1_b, bus.req1_a} : {bus.req0_b, bus.req0_a};
               id <= gnt_id;
               res <= '0;
               cnt <= '0;
               tmr <= '0;
               over <= 1'b0;
               under <= 1'b0;
               tout <= 1'b0;
            end
            ST_LOAD: begin
               op <= fa_shift ? {op[OP_BITS-2:0], 1'b0} : op;
               cnt <= fa_shift ? cnt + 6'd1 : cnt;
               tmr <= fa_shift ? '0 : tmr + 16'd1;
            end
            ST_WAIT: begin
               tmr <= fa_done ? '0 : tmr + 16'd1;
               if (fa_done) begin
                  res <= {res[RES_BITS-2:0], fa_out_c};
                  over <= fa_over;
                  under <= fa_under;
                  cnt <= 6'd1;
               end
            end
            ST_UNLOAD: if (fa_done) begin
               res <= {res[RES_BITS-2:0], fa_out_c};
               cnt <= cnt + 6'd1;
            end
            default: ;
         endcase
      end
endmodule
